// File: rtl/amba_master_seq_if.sv
// Host command/response channel and AMBA_inout slave-side bus, bundled for amba_master_seq.
// Latency: none, wiring only.
// Backpressure: the host holds cmd_valid until cmd_ready; the slave stalls completion with HREADYOUT.
interface amba_master_seq_if;
  // host command channel
  logic         cmd_valid;
  logic [1:0]   cmd_op;
  logic [127:0] cmd_wdata;
  logic         cmd_ready;
  // host response channel
  logic         rsp_valid;
  logic         rsp_err;
  logic [127:0] rsp_rdata;
  logic         busy;
  // slave-side bus
  logic         HCLK;
  logic         HCLK_rise;
  logic         HCLK_fall;
  logic         writek_enable;
  logic         writed_enable;
  logic         readd_enable;
  logic [127:0] HWDATA;
  logic [127:0] HRDATA;
  logic         HREADYOUT;
  logic         HRESP;

  // the sequencer (bus initiator) side
  modport master (
    input  cmd_valid, cmd_op, cmd_wdata, HRDATA, HREADYOUT, HRESP,
    output cmd_ready, rsp_valid, rsp_err, rsp_rdata, busy,
           HCLK, HCLK_rise, HCLK_fall,
           writek_enable, writed_enable, readd_enable, HWDATA
  );

  // the host plus slave environment side
  modport slave (
    output cmd_valid, cmd_op, cmd_wdata, HRDATA, HREADYOUT, HRESP,
    input  cmd_ready, rsp_valid, rsp_err, rsp_rdata, busy,
           HCLK, HCLK_rise, HCLK_fall,
           writek_enable, writed_enable, readd_enable, HWDATA
  );
endinterface

// File: rtl/amba_master_seq.sv
// Bus-side initiator for AMBA_inout: one command in, one strobe out, one response back.
// Latency: strobe one clk after acceptance; response at least WR_WAIT+2 (write) or RD_WAIT+2 (read) clk after acceptance.
// Backpressure: cmd_ready only in IDLE, commands are not queued; HREADYOUT low stretches WAIT up to TIMEOUT.
module amba_master_seq #(
  parameter int HCLK_DIV = 4,
  parameter int WR_WAIT  = 4,
  parameter int RD_WAIT  = 8,
  parameter int TIMEOUT  = 64
) (
  input  logic               clk,
  input  logic               n_rst,
  amba_master_seq_if.master  bus
);

  // HCLK divider geometry: hcnt walks 0..HALF-1 and HCLK flips on the last count
  localparam int HALF = HCLK_DIV / 2;
  localparam int HW   = (HALF > 1) ? $clog2(HALF) : 1;
  localparam logic [HW-1:0] HLAST = HW'(HALF - 1);

  // FSM encoding
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_RESP  = 2'd3;

  // command opcodes
  localparam logic [1:0] OP_WK  = 2'b00;
  localparam logic [1:0] OP_WD  = 2'b01;
  localparam logic [1:0] OP_RD  = 2'b10;
  localparam logic [1:0] OP_BAD = 2'b11;

  // WAIT thresholds in wait_cnt units
  localparam logic [7:0] WR_MIN  = 8'(WR_WAIT);
  localparam logic [7:0] RD_MIN  = 8'(RD_WAIT);
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

  logic [HW-1:0] hcnt;
  logic          hclk_q;
  logic          hrise_q;
  logic          hfall_q;

  logic [1:0]    state;
  logic [1:0]    op_q;
  logic [7:0]    wait_cnt;
  logic [7:0]    wait_min;
  logic          wait_done;
  logic          wait_err;

  logic          wk_en;
  logic          wd_en;
  logic          rd_en;
  logic [127:0]  hwdata_q;
  logic          rsp_valid_q;
  logic          rsp_err_q;
  logic [127:0]  rsp_rdata_q;

  // Free-running HCLK divider; edge pulses are registered alongside the new level
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      hcnt    <= '0;
      hclk_q  <= 1'b0;
      hrise_q <= 1'b0;
      hfall_q <= 1'b0;
    end else if (hcnt == HLAST) begin
      hcnt    <= '0;
      hclk_q  <= ~hclk_q;
      hrise_q <= ~hclk_q;
      hfall_q <= hclk_q;
    end else begin
      hcnt    <= hcnt + 1'b1;
      hrise_q <= 1'b0;
      hfall_q <= 1'b0;
    end
  end

  // Reads need the longer settle window because the slave returns data after an HCLK_rise
  assign wait_min = (op_q == OP_RD) ? RD_MIN : WR_MIN;

  // WAIT exit decision: slave error beats completion, completion beats timeout
  always_comb begin
    wait_done = 1'b0;
    wait_err  = 1'b0;
    if (bus.HRESP) begin
      wait_done = 1'b1;
      wait_err  = 1'b1;
    end else if ((wait_cnt >= wait_min) && bus.HREADYOUT) begin
      wait_done = 1'b1;
    end else if (wait_cnt == TO_LAST) begin
      wait_done = 1'b1;
      wait_err  = 1'b1;
    end
  end

  // Command FSM with registered strobes and response; strobes and rsp_valid are single-cycle
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state       <= S_IDLE;
      op_q        <= OP_WK;
      wait_cnt    <= 8'd0;
      wk_en       <= 1'b0;
      wd_en       <= 1'b0;
      rd_en       <= 1'b0;
      hwdata_q    <= '0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      wk_en       <= 1'b0;
      wd_en       <= 1'b0;
      rd_en       <= 1'b0;
      rsp_valid_q <= 1'b0;
      case (state)
        S_IDLE: begin
          if (bus.cmd_valid) begin
            op_q <= bus.cmd_op;
            // HWDATA only moves on a write so it stays stable across the slave's phases
            if ((bus.cmd_op == OP_WK) || (bus.cmd_op == OP_WD)) begin
              hwdata_q <= bus.cmd_wdata;
            end
            if (bus.cmd_op == OP_BAD) begin
              // illegal op never touches the bus
              state       <= S_RESP;
              rsp_valid_q <= 1'b1;
              rsp_err_q   <= 1'b1;
            end else begin
              state <= S_ISSUE;
              wk_en <= (bus.cmd_op == OP_WK);
              wd_en <= (bus.cmd_op == OP_WD);
              rd_en <= (bus.cmd_op == OP_RD);
            end
          end
        end
        S_ISSUE: begin
          wait_cnt <= 8'd0;
          state    <= S_WAIT;
        end
        S_WAIT: begin
          if (wait_cnt != 8'hFF) begin
            wait_cnt <= wait_cnt + 8'd1;
          end
          if (wait_done) begin
            state       <= S_RESP;
            rsp_valid_q <= 1'b1;
            rsp_err_q   <= wait_err;
            if (!wait_err && (op_q == OP_RD)) begin
              rsp_rdata_q <= bus.HRDATA;
            end
          end
        end
        S_RESP: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.cmd_ready     = (state == S_IDLE);
  assign bus.busy          = (state != S_IDLE);
  assign bus.rsp_valid     = rsp_valid_q;
  assign bus.rsp_err       = rsp_err_q;
  assign bus.rsp_rdata     = rsp_rdata_q;
  assign bus.HCLK          = hclk_q;
  assign bus.HCLK_rise     = hrise_q;
  assign bus.HCLK_fall     = hfall_q;
  assign bus.writek_enable = wk_en;
  assign bus.writed_enable = wd_en;
  assign bus.readd_enable  = rd_en;
  assign bus.HWDATA        = hwdata_q;

  // At most one slave strobe at a time
  a_onehot_strobe: assert property (@(posedge clk) disable iff (!n_rst)
    $onehot0({wk_en, wd_en, rd_en}));

  // A response pulse only ever coincides with the RESP state
  a_rsp_in_resp: assert property (@(posedge clk) disable iff (!n_rst)
    rsp_valid_q |-> (state == S_RESP));

endmodule

// File: tb/tb_amba_master_seq.sv
// Directed bench for amba_master_seq with a transaction-level reference model.
// Latency: model predicts strobe and response cycles from the slave schedule for each command.
// Backpressure: slave HREADYOUT/HRESP follow per-WAIT-cycle schedules; host holds cmd_valid while busy in some tests.
module tb_amba_master_seq;

  localparam int HCLK_DIV = 4;
  localparam int WR_WAIT  = 4;
  localparam int RD_WAIT  = 8;
  localparam int TIMEOUT  = 64;
  localparam int HALF     = HCLK_DIV / 2;

  logic clk   = 1'b0;
  logic n_rst = 1'b0;

  amba_master_seq_if bus ();

  amba_master_seq #(
    .HCLK_DIV (HCLK_DIV),
    .WR_WAIT  (WR_WAIT),
    .RD_WAIT  (RD_WAIT),
    .TIMEOUT  (TIMEOUT)
  ) dut (
    .clk   (clk),
    .n_rst (n_rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // cycle bookkeeping: cyc counts every posedge, e counts posedges since reset release
  int cyc = 0;
  int e   = 0;

  // current transaction as seen by the model
  int           tx_a   = -1000;
  int           tx_r   = -1000;
  logic [1:0]   tx_op  = 2'b00;
  logic [127:0] tx_w   = '0;
  logic         tx_err = 1'b0;

  // slave behaviour, indexed by WAIT cycle number
  logic         rdy_s  [TIMEOUT];
  logic         resp_s [TIMEOUT];
  logic         pre_resp = 1'b0;
  logic [127:0] hrdata_v = '0;

  // held expectations
  logic [127:0] exp_hwdata = '0;
  logic         exp_err    = 1'b0;
  logic [127:0] exp_rdata  = '0;

  // observed event counts and post-reset HCLK capture
  int         n_wk = 0, n_wd = 0, n_rd = 0, n_rsp = 0;
  logic [7:0] hcap = '0, rcap = '0, fcap = '0;

  assign bus.HRDATA = hrdata_v;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, want %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic chk1(input string nm, input logic act, input logic exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %b, want %b (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic chki(input string nm, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, want %0d", nm, act, exp);
    end
  endtask

  task automatic set_sched(input logic rdy, input logic resp);
    for (int i = 0; i < TIMEOUT; i++) begin
      rdy_s[i]  = rdy;
      resp_s[i] = resp;
    end
  endtask

  // Reference rule: scan WAIT cycles k = 0.. for the first exit condition.
  // k = -2 encodes "no WAIT at all" so that response cycle = accept + 2 + k.
  task automatic model_resp(input logic [1:0] op, output int k, output logic err);
    int mn;
    mn  = (op == 2'b10) ? RD_WAIT : WR_WAIT;
    k   = TIMEOUT - 1;
    err = 1'b1;
    if (op == 2'b11) begin
      k = -2;
    end else begin
      for (int i = 0; i < TIMEOUT; i++) begin
        if (resp_s[i]) begin
          k = i; err = 1'b1; break;
        end
        if (i >= mn && rdy_s[i]) begin
          k = i; err = 1'b0; break;
        end
      end
    end
  endtask

  // Issue one command and let it complete; lat = response cycle minus acceptance cycle.
  task automatic run_cmd(input logic [1:0] op, input logic [127:0] wd, input bit hold_busy,
                         output int lat);
    int   k;
    logic err;
    model_resp(op, k, err);
    @(posedge clk); #1;
    tx_op  = op;
    tx_w   = wd;
    tx_err = err;
    tx_a   = cyc + 1;
    tx_r   = tx_a + 2 + k;
    lat    = tx_r - tx_a;
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = op;
    bus.cmd_wdata = wd;
    @(posedge clk); #1;
    if (hold_busy) begin
      // a different request stays up across every busy edge and must be ignored
      bus.cmd_op    = 2'b10;
      bus.cmd_wdata = ~wd;
      repeat (lat + 1) @(posedge clk);
      #1;
      bus.cmd_valid = 1'b0;
      repeat (2) @(posedge clk);
    end else begin
      bus.cmd_valid = 1'b0;
      repeat (lat + 2) @(posedge clk);
    end
  endtask

  // cycle counters
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (!n_rst) e <= 0;
    else        e <= e + 1;
  end

  // slave model drives HREADYOUT/HRESP just after each edge
  always @(posedge clk) begin : slave_drv
    int idx;
    #1;
    idx = cyc - tx_a - 1;
    if (idx >= 0 && idx < TIMEOUT) begin
      bus.HREADYOUT = rdy_s[idx];
      bus.HRESP     = resp_s[idx];
    end else begin
      bus.HREADYOUT = 1'b1;
      bus.HRESP     = pre_resp;
    end
  end

  // compare every output against the model on every falling edge
  always @(negedge clk) begin : cmp
    logic in_rst, e_busy, e_wk, e_wd, e_rd, e_rv, e_h, e_hr, e_hf, edge_now;
    in_rst = !n_rst;
    if (in_rst) begin
      exp_hwdata = '0;
      exp_err    = 1'b0;
      exp_rdata  = '0;
    end else begin
      if (cyc == tx_a && (tx_op == 2'b00 || tx_op == 2'b01)) exp_hwdata = tx_w;
      if (cyc == tx_r) begin
        exp_err = tx_err;
        if (!tx_err && tx_op == 2'b10) exp_rdata = hrdata_v;
      end
    end
    e_busy   = !in_rst && cyc >= tx_a && cyc <= tx_r;
    e_wk     = !in_rst && cyc == tx_a && tx_op == 2'b00;
    e_wd     = !in_rst && cyc == tx_a && tx_op == 2'b01;
    e_rd     = !in_rst && cyc == tx_a && tx_op == 2'b10;
    e_rv     = !in_rst && cyc == tx_r;
    e_h      = !in_rst && ((e / HALF) % 2 == 1);
    edge_now = !in_rst && e > 0 && (e % HALF == 0);
    e_hr     = edge_now && e_h;
    e_hf     = edge_now && !e_h;

    chk1("busy",          bus.busy,          e_busy);
    chk1("cmd_ready",     bus.cmd_ready,     !e_busy);
    chk1("writek_enable", bus.writek_enable, e_wk);
    chk1("writed_enable", bus.writed_enable, e_wd);
    chk1("readd_enable",  bus.readd_enable,  e_rd);
    chk1("rsp_valid",     bus.rsp_valid,     e_rv);
    chk1("rsp_err",       bus.rsp_err,       exp_err);
    chk ("rsp_rdata",     bus.rsp_rdata,     exp_rdata);
    chk ("HWDATA",        bus.HWDATA,        exp_hwdata);
    chk1("HCLK",          bus.HCLK,          e_h);
    chk1("HCLK_rise",     bus.HCLK_rise,     e_hr);
    chk1("HCLK_fall",     bus.HCLK_fall,     e_hf);

    if (!in_rst && e >= 1 && e <= 8) begin
      hcap[e-1] = bus.HCLK;
      rcap[e-1] = bus.HCLK_rise;
      fcap[e-1] = bus.HCLK_fall;
    end
    if (bus.writek_enable) n_wk++;
    if (bus.writed_enable) n_wd++;
    if (bus.readd_enable)  n_rd++;
    if (bus.rsp_valid)     n_rsp++;
  end

  initial begin
    int lat;
    bus.cmd_valid = 1'b0;
    bus.cmd_op    = 2'b00;
    bus.cmd_wdata = '0;
    set_sched(1'b1, 1'b0);

    // reset state
    repeat (2) @(posedge clk);
    #1;
    chk1("rst_cmd_ready", bus.cmd_ready, 1'b1);
    chk1("rst_busy",      bus.busy,      1'b0);
    chk ("rst_hwdata",    bus.HWDATA,    128'h0);
    n_rst = 1'b1;
    repeat (3) @(posedge clk);

    // 1: write key, HREADYOUT low in WAIT cycles 3..5, extra request held while busy
    set_sched(1'b1, 1'b0);
    rdy_s[3] = 1'b0; rdy_s[4] = 1'b0; rdy_s[5] = 1'b0;
    hrdata_v = 128'h5555;
    run_cmd(2'b00, 128'h0123456789ABCDEF0123456789ABCDEF, 1'b1, lat);
    chki("t1_latency", lat, 8);
    chk ("t1_hwdata",  bus.HWDATA, 128'h0123456789ABCDEF0123456789ABCDEF);

    // 2: read, slave ready throughout; HRESP high while IDLE/ISSUE must be ignored
    set_sched(1'b1, 1'b0);
    hrdata_v = 128'hDEADBEEF;
    pre_resp = 1'b1;
    run_cmd(2'b10, 128'hFFFF0000FFFF0000FFFF0000FFFF0000, 1'b0, lat);
    pre_resp = 1'b0;
    chki("t2_latency", lat, 10);
    chk ("t2_rdata",   bus.rsp_rdata, 128'hDEADBEEF);
    chk1("t2_err",     bus.rsp_err,   1'b0);
    chk ("t2_hwdata",  bus.HWDATA,    128'h0123456789ABCDEF0123456789ABCDEF);

    // 3: write data, HRESP at WAIT cycle 2
    set_sched(1'b1, 1'b0);
    resp_s[2] = 1'b1;
    run_cmd(2'b01, 128'hA5A5A5A5A5A5A5A5A5A5A5A5A5A5A5A5, 1'b0, lat);
    chki("t3_latency", lat, 4);
    chk1("t3_err",     bus.rsp_err,   1'b1);
    chk ("t3_rdata",   bus.rsp_rdata, 128'hDEADBEEF);

    // 4: read with HREADYOUT stuck low -> timeout at wait_cnt 63
    set_sched(1'b0, 1'b0);
    hrdata_v = 128'hBAD0BAD0;
    run_cmd(2'b10, 128'h1111, 1'b0, lat);
    chki("t4_latency",  lat, 65);
    chk1("t4_err",      bus.rsp_err,   1'b1);
    chk ("t4_rdata",    bus.rsp_rdata, 128'hDEADBEEF);
    chk1("t4_cmd_ready", bus.cmd_ready, 1'b1);

    // 5: illegal op, request held while busy
    set_sched(1'b1, 1'b0);
    run_cmd(2'b11, 128'h2222, 1'b1, lat);
    chki("t5_latency", lat, 0);
    chk1("t5_err",     bus.rsp_err, 1'b1);
    chk ("t5_hwdata",  bus.HWDATA,  128'hA5A5A5A5A5A5A5A5A5A5A5A5A5A5A5A5);

    // 6: reset pulse while in WAIT, then HCLK restart and a clean command
    set_sched(1'b0, 1'b0);
    @(posedge clk); #1;
    tx_op  = 2'b00;
    tx_w   = 128'h6666;
    tx_err = 1'b1;
    tx_a   = cyc + 1;
    tx_r   = tx_a + 2 + (TIMEOUT - 1);
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = 2'b00;
    bus.cmd_wdata = 128'h6666;
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    n_rst = 1'b0;
    tx_a  = -1000;
    tx_r  = -1000;
    repeat (3) @(posedge clk);
    #1;
    chk ("t6_rst_hwdata", bus.HWDATA,    128'h0);
    chk1("t6_rst_err",    bus.rsp_err,   1'b0);
    n_rst = 1'b1;
    repeat (12) @(posedge clk);
    #1;
    chk("t6_hclk_seq", {120'h0, hcap}, {120'h0, 8'b01100110});
    chk("t6_rise_seq", {120'h0, rcap}, {120'h0, 8'b00100010});
    chk("t6_fall_seq", {120'h0, fcap}, {120'h0, 8'b10001000});

    set_sched(1'b1, 1'b0);
    run_cmd(2'b01, 128'h7777, 1'b0, lat);
    chki("t6_latency", lat, 6);

    chki("cnt_writek", n_wk,  2);
    chki("cnt_writed", n_wd,  2);
    chki("cnt_readd",  n_rd,  2);
    chki("cnt_rsp",    n_rsp, 6);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
